// File: rtl/bcd_scan_pkg.sv
// rtl/bcd_scan_pkg.sv - segment patterns and divider/width helpers for bcd_counter_scan
package bcd_scan_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Active-low a..g in [7:1], dp in [0] held off.
  localparam logic [7:0] SEG_0     = 8'b0000001_1;
  localparam logic [7:0] SEG_1     = 8'b1001111_1;
  localparam logic [7:0] SEG_2     = 8'b0010010_1;
  localparam logic [7:0] SEG_3     = 8'b0000110_1;
  localparam logic [7:0] SEG_4     = 8'b1001100_1;
  localparam logic [7:0] SEG_5     = 8'b0100100_1;
  localparam logic [7:0] SEG_6     = 8'b0100000_1;
  localparam logic [7:0] SEG_7     = 8'b0001111_1;
  localparam logic [7:0] SEG_8     = 8'b0000000_1;
  localparam logic [7:0] SEG_9     = 8'b0000100_1;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic int calc_div(input int clk_hz, input int rate_hz);
    return clk_hz / rate_hz;
  endfunction

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int calc_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// rtl/bcd_digit_cell.sv - one decade of the BCD counter with carry/borrow out
module bcd_digit_cell
  import bcd_scan_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       up_down,
  input  logic       step_in,
  input  logic       load,
  input  logic [3:0] load_nibble,
  output logic [3:0] nibble,
  output logic       step_out
);

  logic [3:0] nib_q, nib_d;

  always_comb begin
    nib_d = nib_q;
    if (load) begin
      nib_d = (load_nibble > BCD_MAX) ? 4'd0 : load_nibble;
    end else if (step_in) begin
      if (up_down) nib_d = (nib_q == BCD_MAX) ? 4'd0 : nib_q + 4'd1;
      else         nib_d = (nib_q == 4'd0) ? BCD_MAX : nib_q - 4'd1;
    end
  end

  // Ripples into the next decade when this one rolls over in the active direction.
  assign step_out = step_in & (up_down ? (nib_q == BCD_MAX) : (nib_q == 4'd0));
  assign nibble   = nib_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) nib_q <= 4'd0;
    else     nib_q <= nib_d;
  end

endmodule

// File: rtl/bcd_counter_scan.sv
// rtl/bcd_counter_scan.sv - N-digit BCD up/down counter with multiplexed seven-segment drive
// Optional leading-zero blanking via BCD_LZ_BLANK_EN.
module bcd_counter_scan
  import bcd_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_HZ     = 100000000,
  parameter int TICK_HZ    = 10,
  parameter int SCAN_HZ    = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up_down,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic                    wrap,
  output logic [NUM_DIGITS-1:0]   digit,
  output logic [7:0]              Seven_Seg
);

  localparam int TICK_DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int SCAN_DIV = calc_div(CLK_HZ, SCAN_HZ);
  localparam int PRE_W    = calc_width(TICK_DIV);
  localparam int SCN_W    = calc_width(SCAN_DIV);
  localparam int IDX_W    = calc_width(NUM_DIGITS);

  logic [PRE_W-1:0]      presc_q, presc_d;
  logic [SCN_W-1:0]      scan_q, scan_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  wrap_q, wrap_d;
  logic [NUM_DIGITS-1:0] digit_q, digit_d;
  logic [7:0]            seg_q, seg_d;
  logic                  tick;
  logic [NUM_DIGITS:0]   step;
  logic                  blank;

  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    if (en) begin
      if (presc_q == PRE_W'(TICK_DIV - 1)) begin
        tick    = 1'b1;
        presc_d = '0;
      end else begin
        presc_d = presc_q + PRE_W'(1);
      end
    end
  end

  assign step[0] = tick;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit_cell u_cell (
      .clk         (clk),
      .rst         (rst),
      .up_down     (up_down),
      .step_in     (step[g]),
      .load        (load),
      .load_nibble (load_value[4*g +: 4]),
      .nibble      (count_bcd[4*g +: 4]),
      .step_out    (step[g+1])
    );
  end

  // A ripple out of the top decade is the wrap, unless a load overrides the step.
  assign wrap_d = step[NUM_DIGITS] & ~load;

  always_comb begin
    scan_d = scan_q + SCN_W'(1);
    idx_d  = idx_q;
    if (scan_q == SCN_W'(SCAN_DIV - 1)) begin
      scan_d = '0;
      idx_d  = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

`ifdef BCD_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] lz;

  always_comb begin : lz_scan
    logic all_zero;
    all_zero = 1'b1;
    lz       = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero = all_zero & (count_bcd[4*k +: 4] == 4'd0);
      lz[k]    = all_zero;
    end
  end

  assign blank = (idx_q != '0) && lz[idx_q];
`else
  assign blank = 1'b0;
`endif

  // Anode and segments are registered together so they always switch in the same cycle.
  always_comb begin
    digit_d = ~(NUM_DIGITS'(1) << idx_q);
    seg_d   = blank ? SEG_BLANK : seg_decode(count_bcd[4*idx_q +: 4]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      scan_q  <= '0;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
      digit_q <= '1;
      seg_q   <= SEG_BLANK;
    end else begin
      presc_q <= presc_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
      digit_q <= digit_d;
      seg_q   <= seg_d;
    end
  end

  assign wrap      = wrap_q;
  assign digit     = digit_q;
  assign Seven_Seg = seg_q;

endmodule

// File: tb/tb_bcd_counter_scan.sv
// tb/tb_bcd_counter_scan.sv - directed scoreboard bench for bcd_counter_scan
// Expected leading digits follow BCD_LZ_BLANK_EN.
module tb_bcd_counter_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        up_down = 1'b1;
  logic        load = 1'b0;
  logic [15:0] load_value = 16'h0000;
  logic [15:0] count_bcd;
  logic        wrap;
  logic [3:0]  digit;
  logic [7:0]  Seven_Seg;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int p;
  string       tag_q[$];
  logic [31:0] val_q[$];

  bcd_counter_scan #(
    .NUM_DIGITS (4),
    .CLK_HZ     (100),
    .TICK_HZ    (10),
    .SCAN_HZ    (50)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .up_down    (up_down),
    .load       (load),
    .load_value (load_value),
    .count_bcd  (count_bcd),
    .wrap       (wrap),
    .digit      (digit),
    .Seven_Seg  (Seven_Seg)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the scan model derives the expected anode from it.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    tag_q.push_back(tag);
    val_q.push_back(val);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    string       t;
    logic [31:0] v;
    if (val_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty observed=%h expected=entry", obs);
    end else begin
      t = tag_q.pop_front();
      v = val_q.pop_front();
      check(t, obs, v);
    end
  endtask

  function automatic logic [7:0] exp_seg(input int pos);
    case (pos)
      0:       return 8'b0001111_1;
      1:       return 8'b0000110_1;
`ifdef BCD_LZ_BLANK_EN
      default: return 8'hFF;
`else
      default: return 8'b0000001_1;
`endif
    endcase
  endfunction

  initial begin
    step(2);
    check("rst_count", count_bcd, 32'h0);
    check("rst_wrap", wrap, 32'h0);
    check("rst_digit", digit, 32'hF);
    check("rst_seg", Seven_Seg, 32'hFF);

    rst = 1'b0; en = 1'b1; up_down = 1'b1;
    check("pre_drive_digit", digit, 32'hF);
    step(1);
    check("first_drive_digit", digit, 32'hE);
    check("first_drive_seg", Seven_Seg, 32'h03);

    step(118);
    push("count_e119", 32'h0011); pop_check(count_bcd);
    step(1);
    push("count_e120", 32'h0012); pop_check(count_bcd);

    load_value = 16'h9998; load = 1'b1;
    push("load_9998", 32'h9998);
    step(1); load = 1'b0;
    pop_check(count_bcd);
    step(9);
    push("up_9999", 32'h9999); pop_check(count_bcd);
    check("no_wrap_9999", wrap, 32'h0);
    step(10);
    push("up_wrap_0000", 32'h0000); pop_check(count_bcd);
    check("wrap_up_pulse", wrap, 32'h1);
    step(1);
    check("wrap_up_clear", wrap, 32'h0);

    load_value = 16'h0001; up_down = 1'b0; load = 1'b1;
    push("load_0001", 32'h0001);
    step(1); load = 1'b0;
    pop_check(count_bcd);
    step(8);
    push("down_0000", 32'h0000); pop_check(count_bcd);
    check("no_wrap_0000", wrap, 32'h0);
    step(10);
    push("down_wrap_9999", 32'h9999); pop_check(count_bcd);
    check("wrap_down_pulse", wrap, 32'h1);
    step(1);
    check("wrap_down_clear", wrap, 32'h0);

    load_value = 16'h12F4; load = 1'b1;
    push("load_sanitize", 32'h1204);
    step(1); load = 1'b0;
    pop_check(count_bcd);
    check("no_wrap_on_load", wrap, 32'h0);

    step(7);
    load_value = 16'h0500; up_down = 1'b1; load = 1'b1;
    push("load_beats_tick", 32'h0500);
    step(1); load = 1'b0;
    pop_check(count_bcd);

    step(3); en = 1'b0;
    step(30);
    push("hold_en_low", 32'h0500); pop_check(count_bcd);
    en = 1'b1;
    step(6);
    push("hold_presc_e209", 32'h0500); pop_check(count_bcd);
    step(1);
    push("resume_e210", 32'h0501); pop_check(count_bcd);

    en = 1'b0; load_value = 16'h0037; load = 1'b1;
    step(1); load = 1'b0;
    step(1);
    for (int i = 0; i < 8; i++) begin
      step(1);
      p = ((cyc - 1) / 2) % 4;
      push($sformatf("scan_digit_%0d", i), 32'(~(4'b0001 << p) & 4'hF));
      push($sformatf("scan_seg_%0d", i), 32'(exp_seg(p)));
      pop_check(digit);
      pop_check(Seven_Seg);
    end

    load_value = 16'h4321; load = 1'b1;
    push("load_4321", 32'h4321);
    step(1); load = 1'b0;
    pop_check(count_bcd);
    step(3);
    #2 rst = 1'b1;
    #1;
    check("midrst_count", count_bcd, 32'h0);
    check("midrst_digit", digit, 32'hF);
    check("midrst_seg", Seven_Seg, 32'hFF);
    check("midrst_wrap", wrap, 32'h0);
    step(1);
    rst = 1'b0;
    check("release_blank_digit", digit, 32'hF);
    check("release_blank_seg", Seven_Seg, 32'hFF);
    step(1);
    check("redrive_digit", digit, 32'hE);
    check("redrive_seg_zero", Seven_Seg, 32'h03);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_counter_scan.md
Name: bcd_counter_scan

Overview:
- Parametrised successor to the fixed 4-digit decimal counter and display pair.
- Holds an N-digit BCD counter that steps at a programmable rate, either up or down, with synchronous load and enable.
- Time-multiplexes the digits onto a common-anode seven-segment display.
- Sits directly under the board top level: drives digit/Seven_Seg and exports the BCD value and a wrap pulse.

Parameters:
- NUM_DIGITS, 4, number of BCD digits and anodes (1..8).
- CLK_HZ, 100000000, input clock frequency.
- TICK_HZ, 10, count-step rate; TICK_DIV = CLK_HZ/TICK_HZ (must be ≥2).
- SCAN_HZ, 1000, per-digit refresh rate; SCAN_DIV = CLK_HZ/SCAN_HZ (must be ≥2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- en  in  1  count enable; prescaler and counter freeze while low
- up_down  in  1  1 = count up, 0 = count down
- load  in  1  synchronous load strobe
- load_value  in  4*NUM_DIGITS  BCD value to load; digit 0 (least significant) in bits [3:0]
- count_bcd  out  4*NUM_DIGITS  current count, same packing as load_value
- wrap  out  1  one-cycle pulse on wrap-around
- digit  out  NUM_DIGITS  anode enables, active-low, one-hot-zero; bit 0 = least significant digit
- Seven_Seg  out  8  segments a,b,c,d,e,f,g,dp, active-low; dp always off (1)

Behaviour:
- Reset (async assert, sync release): count_bcd=0, wrap=0, digit=all 1, Seven_Seg=8'hFF, prescaler=0, scan counter=0, scan index=0.
- Tick prescaler: counts 0..TICK_DIV-1 while en=1, holds while en=0. tick=1 in the cycle the prescaler equals TICK_DIV-1, then it returns to 0.
- Count step on tick (en=1, load=0):
  - Up: digit 0 increments; a digit at 9 goes to 0 and carries into the next digit. All-9s goes to all-0 and asserts wrap the next cycle.
  - Down: digit 0 decrements; a digit at 0 goes to 9 and borrows. All-0s goes to all-9s and asserts wrap.
- count_bcd updates one cycle after tick (registered).
- Load: load=1 sets count_bcd=load_value next cycle, regardless of en or tick.
  - Load wins over a coincident tick; the prescaler is not reset by load.
  - Any load nibble >9 is stored as 0. No wrap pulse on load.
- up_down is sampled only on tick; changing it between ticks has no side effect.
- Scan counter: free-running 0..SCAN_DIV-1, independent of en.
  - At terminal count, scan index advances k -> k+1, and NUM_DIGITS-1 -> 0.
- Display outputs are registered from the scan index and count_bcd:
  - digit[k]=0 only for the current index.
  - Seven_Seg = decode(count_bcd nibble k).
  - Both change in the same cycle: no ghosting cycle with mismatched anode and segments.
  - The first valid drive is the cycle after the first clock following reset release (index 0).
- Decode table (a..g, 0=lit): 0→0000001, 1→1001111, 2→0010010, 3→0000110, 4→1001100, 5→0100100, 6→0100000, 7→0001111, 8→0000000, 9→0000100.
- Reset mid-count clears everything immediately; outputs blank until the next clock edge after release.

Optional Feature:
- Macro: BCD_LZ_BLANK_EN.
- Defined: leading-zero blanking. Any digit k>0 whose nibble and all higher nibbles are 0 drives Seven_Seg=8'hFF; its anode still strobes, keeping the duty cycle constant. Digit 0 is never blanked, so 0000 displays as "0".
- Undefined: all digits always shown, including leading zeros.

Decomposition:
- Package bcd_scan_pkg holds:
  - the seven-segment pattern constants for 0–9 and blank;
  - a function computing the divider from CLK_HZ and rate;
  - a function computing the required counter width (clog2).
- One natural sub-module: bcd_digit_cell, one decade. It takes up_down, step_in and load inputs and produces its nibble plus carry/borrow out. It is instantiated NUM_DIGITS times in a generate chain. The scan/decode logic stays in the parent.

Test Plan (all with CLK_HZ=100, TICK_HZ=10, SCAN_HZ=50 → TICK_DIV=10, SCAN_DIV=2, NUM_DIGITS=4):
- Reset then en=1, up_down=1 for 120 cycles → count_bcd=0x0012. Ticks occur every 10 cycles with no skipped or double steps.
- load_value=0x9998, load pulse, then 2 up ticks → 0x9999 then 0x0000. wrap is high exactly one cycle after the second tick.
- load_value=0x0001, up_down=0, 2 ticks → 0x0000 then 0x9999 with one wrap pulse. Then load 0x12F4 → count_bcd=0x1204.
- load asserted in the same cycle as a tick with load_value=0x0500 → 0x0500, not 0x0501. Deasserting en for 30 cycles holds the count and the prescaler value.
- Count=0x0037, scan 8 cycles → digit follows 1110,1101,1011,0111 repeating. Seven_Seg for digit 0 is 0001111_1 and for digit 1 is 0000110_1. Digits 2–3 show "0" (macro undefined) or 8'hFF (macro defined).
- Assert rst mid-scan with count 0x4321 → in the same cycle count_bcd=0, digit=1111, Seven_Seg=8'hFF, wrap=0.
